// File: rtl/uart_pkg.sv
// Shared UART definitions: feeder FSM encoding, byte width, frame timing
// and the default FIFO depth used by the transmit-side feeder.
package uart_pkg;

    localparam int BYTE_W         = 8;
    // bclk cycles per 10-bit frame at 16x oversampling
    localparam int FRAME_CYC      = 160;
    localparam int DEPTH_LOG2_DEF = 4;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        LAUNCH    = 2'd1,
        WAIT_ACK  = 2'd2,
        WAIT_DONE = 2'd3
    } feeder_state_t;

endpackage : uart_pkg

// File: rtl/uart_tx_feeder_if.sv
// Producer/transmitter signal bundle for uart_tx_feeder.
// The slave modport is the feeder; the master modport is its environment
// (producer write port plus the transmitter's start/tx_din/tx_done handshake).
// tx_err exists only when UART_TX_FEEDER_TIMEOUT_EN is defined.
interface uart_tx_feeder_if #(
    parameter int DEPTH_LOG2 = uart_pkg::DEPTH_LOG2_DEF
);
    import uart_pkg::*;

    logic                wr_en;
    logic [BYTE_W-1:0]   wr_data;
    logic                ovf_clr;
    logic                tx_done;
    logic                start;
    logic [BYTE_W-1:0]   tx_din;
    logic                full;
    logic                empty;
    logic [DEPTH_LOG2:0] count;
    logic                overflow;
    logic                busy;
`ifdef UART_TX_FEEDER_TIMEOUT_EN
    logic                tx_err;
`endif

    modport master (
        output wr_en, wr_data, ovf_clr, tx_done,
`ifdef UART_TX_FEEDER_TIMEOUT_EN
        input  tx_err,
`endif
        input  start, tx_din, full, empty, count, overflow, busy
    );

    modport slave (
        input  wr_en, wr_data, ovf_clr, tx_done,
`ifdef UART_TX_FEEDER_TIMEOUT_EN
        output tx_err,
`endif
        output start, tx_din, full, empty, count, overflow, busy
    );

endinterface : uart_tx_feeder_if

// File: rtl/uart_sync_fifo.sv
// Single-clock byte FIFO with registered occupancy count.
// full/empty are decoded from the registered count; writes while full and
// pops while empty are ignored. RAM contents are not reset.
module uart_sync_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH_LOG2 = DEPTH_LOG2_DEF
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                wr_en_i,
    input  logic [BYTE_W-1:0]   wr_data_i,
    input  logic                rd_en_i,
    output logic [BYTE_W-1:0]   rd_data_o,
    output logic [DEPTH_LOG2:0] count_o,
    output logic                full_o,
    output logic                empty_o
);

    localparam int DEPTH = 2 ** DEPTH_LOG2;
    localparam int CNT_W = DEPTH_LOG2 + 1;

    logic [BYTE_W-1:0]     mem_q [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
    logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic                  push, pop;

    assign full_o    = (count_q == CNT_W'(DEPTH));
    assign empty_o   = (count_q == '0);
    assign count_o   = count_q;
    assign rd_data_o = mem_q[rd_ptr_q];

    // a pop in the same cycle never frees room for a write seen against full
    assign push = wr_en_i && !full_o;
    assign pop  = rd_en_i && !empty_o;

    // next pointer and occupancy values
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + DEPTH_LOG2'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + DEPTH_LOG2'(1);
        end
        unique case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // pointer and count registers, flushed by reset
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // storage array write port, no reset
    always_ff @(posedge clk_i) begin
        if (push) begin
            mem_q[wr_ptr_q] <= wr_data_i;
        end
    end

endmodule : uart_sync_fifo

// File: rtl/uart_tx_feeder.sv
// UART transmit feeder: buffers producer bytes in uart_sync_fifo and hands
// them one at a time to the transmitter via start/tx_din/tx_done, all on bclk.
// Optional: define UART_TX_FEEDER_TIMEOUT_EN to add a watchdog on the
// transmitter handshake (TIMEOUT_CYC cycles) with sticky tx_err.
module uart_tx_feeder
    import uart_pkg::*;
#(
    parameter int DEPTH_LOG2 = DEPTH_LOG2_DEF
`ifdef UART_TX_FEEDER_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYC = 255
`endif
) (
    input  logic             bclk,
    input  logic             rst,
    uart_tx_feeder_if.slave  bus
);

    feeder_state_t       state_q, state_d;
    logic                start_q, start_d;
    logic [BYTE_W-1:0]   tx_din_q, tx_din_d;
    logic                ovf_q, ovf_d;
    logic                fifo_pop;
    logic [BYTE_W-1:0]   fifo_rdata;
    logic [DEPTH_LOG2:0] fifo_count;
    logic                fifo_full;
    logic                fifo_empty;

`ifdef UART_TX_FEEDER_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);

    logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;
    logic             tmo_hit;
    logic             err_q, err_d;
`endif

    uart_sync_fifo #(
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_fifo (
        .clk_i     (bclk),
        .rst_ni    (rst),
        .wr_en_i   (bus.wr_en),
        .wr_data_i (bus.wr_data),
        .rd_en_i   (fifo_pop),
        .rd_data_o (fifo_rdata),
        .count_o   (fifo_count),
        .full_o    (fifo_full),
        .empty_o   (fifo_empty)
    );

    // launch FSM: pop and present a byte, pulse start, then track tx_done low/high
    always_comb begin
        state_d   = state_q;
        start_d   = 1'b0;
        tx_din_d  = tx_din_q;
        fifo_pop  = 1'b0;
`ifdef UART_TX_FEEDER_TIMEOUT_EN
        tmo_cnt_d = '0;
        tmo_hit   = 1'b0;
`endif
        unique case (state_q)
            IDLE: begin
                if (!fifo_empty && bus.tx_done) begin
                    start_d  = 1'b1;
                    tx_din_d = fifo_rdata;
                    fifo_pop = 1'b1;
                    state_d  = LAUNCH;
                end
            end
            LAUNCH:    state_d = WAIT_ACK;
            WAIT_ACK:  if (!bus.tx_done) state_d = WAIT_DONE;
            WAIT_DONE: if (bus.tx_done)  state_d = IDLE;
            default:   state_d = IDLE;
        endcase
`ifdef UART_TX_FEEDER_TIMEOUT_EN
        // only a wait state that is not already advancing can time out
        if ((state_q == WAIT_ACK) || (state_q == WAIT_DONE)) begin
            tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
            if ((tmo_cnt_d == TMO_W'(TIMEOUT_CYC)) && (state_d == state_q)) begin
                tmo_hit   = 1'b1;
                tmo_cnt_d = '0;
                state_d   = IDLE;
            end
        end
`endif
    end

    // sticky error flags: a new event wins over a same-cycle clear
    always_comb begin
        ovf_d = ovf_q;
        if (bus.ovf_clr) begin
            ovf_d = 1'b0;
        end
        if (bus.wr_en && fifo_full) begin
            ovf_d = 1'b1;
        end
`ifdef UART_TX_FEEDER_TIMEOUT_EN
        err_d = err_q;
        if (bus.ovf_clr) begin
            err_d = 1'b0;
        end
        if (tmo_hit) begin
            err_d = 1'b1;
        end
`endif
    end

    // FSM and output registers
    always_ff @(posedge bclk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            start_q   <= 1'b0;
            tx_din_q  <= '0;
            ovf_q     <= 1'b0;
`ifdef UART_TX_FEEDER_TIMEOUT_EN
            tmo_cnt_q <= '0;
            err_q     <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            start_q   <= start_d;
            tx_din_q  <= tx_din_d;
            ovf_q     <= ovf_d;
`ifdef UART_TX_FEEDER_TIMEOUT_EN
            tmo_cnt_q <= tmo_cnt_d;
            err_q     <= err_d;
`endif
        end
    end

    assign bus.start    = start_q;
    assign bus.tx_din   = tx_din_q;
    assign bus.full     = fifo_full;
    assign bus.empty    = fifo_empty;
    assign bus.count    = fifo_count;
    assign bus.overflow = ovf_q;
    assign bus.busy     = (state_q != IDLE) || !fifo_empty;
`ifdef UART_TX_FEEDER_TIMEOUT_EN
    assign bus.tx_err   = err_q;
`endif

endmodule : uart_tx_feeder

// File: tb/tb_uart_tx_feeder.sv
// Directed bench for uart_tx_feeder with a small behavioural transmitter
// that captures each launched byte and holds tx_done low for one frame.
module tb_uart_tx_feeder;
    import uart_pkg::*;

    logic bclk;
    logic rst;

    uart_tx_feeder_if #(.DEPTH_LOG2(4)) bus ();

    uart_tx_feeder #(.DEPTH_LOG2(4)) dut (
        .bclk (bclk),
        .rst  (rst),
        .bus  (bus)
    );

    initial bclk = 1'b0;
    always #5 bclk = ~bclk;

    int n_tests = 0;
    int n_fail  = 0;

    // transmitter model state
    int         cyc       = 0;
    int         busy_cnt  = 0;
    int         frame_len = FRAME_CYC;
    logic       hold      = 1'b0;
    logic       mute      = 1'b0;
    logic [7:0] rx_q[$];
    int         gaps[$];
    int         rise_cyc  = 0;
    logic       rise_pend = 1'b0;
    logic       prev_start = 1'b0;
    int         dbl_start = 0;

    assign bus.tx_done = (busy_cnt == 0) && !hold;

    always @(posedge bclk) cyc <= cyc + 1;

    always @(posedge bclk or negedge rst) begin
        if (!rst) begin
            busy_cnt   <= 0;
            prev_start <= 1'b0;
            rise_pend  <= 1'b0;
        end else begin
            prev_start <= bus.start;
            if (bus.start && prev_start) dbl_start <= dbl_start + 1;
            if (hold) rise_pend <= 1'b0;
            if (bus.start && !mute) begin
                rx_q.push_back(bus.tx_din);
                if (rise_pend) gaps.push_back(cyc - 1 - rise_cyc);
                rise_pend <= 1'b0;
                busy_cnt  <= frame_len;
            end else if (busy_cnt > 0) begin
                busy_cnt <= busy_cnt - 1;
                if (busy_cnt == 1) begin
                    rise_pend <= 1'b1;
                    rise_cyc  <= cyc;
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wr_byte(input logic [7:0] b);
        bus.wr_en   = 1'b1;
        bus.wr_data = b;
        @(negedge bclk);
        bus.wr_en   = 1'b0;
    endtask

    task automatic clr_ovf();
        bus.ovf_clr = 1'b1;
        @(negedge bclk);
        bus.ovf_clr = 1'b0;
    endtask

    task automatic wait_rx(input string tag, input int n, input int limit);
        for (int i = 0; i < limit && rx_q.size() < n; i++) @(negedge bclk);
        chk(tag, 32'(rx_q.size() >= n), 32'd1);
    endtask

    task automatic wait_idle(input string tag, input int limit);
        for (int i = 0; i < limit && (bus.busy || !bus.tx_done); i++) @(negedge bclk);
        chk(tag, 32'(bus.busy), 32'd0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int gbase;
        int errs;

        rst         = 1'b0;
        bus.wr_en   = 1'b0;
        bus.wr_data = 8'h00;
        bus.ovf_clr = 1'b0;
        repeat (3) @(negedge bclk);

        // reset values
        chk("rst_start",    32'(bus.start),    32'd0);
        chk("rst_tx_din",   32'(bus.tx_din),   32'h00);
        chk("rst_count",    32'(bus.count),    32'd0);
        chk("rst_empty",    32'(bus.empty),    32'd1);
        chk("rst_full",     32'(bus.full),     32'd0);
        chk("rst_overflow", 32'(bus.overflow), 32'd0);
        chk("rst_busy",     32'(bus.busy),     32'd0);
        rst = 1'b1;
        @(negedge bclk);

        // 1: single byte latency and one-cycle start pulse
        wr_byte(8'hA5);
        chk("t1_count_after_wr", 32'(bus.count), 32'd1);
        chk("t1_start_n",        32'(bus.start), 32'd0);
        chk("t1_busy",           32'(bus.busy),  32'd1);
        @(negedge bclk);
        chk("t1_start_n1",  32'(bus.start),  32'd1);
        chk("t1_tx_din",    32'(bus.tx_din), 32'hA5);
        chk("t1_count_pop", 32'(bus.count),  32'd0);
        @(negedge bclk);
        chk("t1_start_n2",  32'(bus.start),  32'd0);
        chk("t1_tx_din_hold", 32'(bus.tx_din), 32'hA5);
        wait_rx("t1_rx_wait", 1, 50);
        chk("t1_rx_byte", 32'(rx_q[0]), 32'hA5);
        wait_idle("t1_idle", 1000);

        // 2: burst of three, transmitter blocked while writing
        hold = 1'b1;
        bus.wr_en = 1'b1; bus.wr_data = 8'h01; @(negedge bclk);
        bus.wr_data = 8'h02; @(negedge bclk);
        bus.wr_data = 8'h03; @(negedge bclk);
        bus.wr_en = 1'b0;
        chk("t2_count3", 32'(bus.count), 32'd3);
        chk("t2_no_launch_while_txbusy", 32'(bus.start), 32'd0);
        base  = rx_q.size();
        gbase = gaps.size();
        hold  = 1'b0;
        wait_rx("t2_rx_wait", base + 3, 1000);
        wait_idle("t2_idle", 1000);
        chk("t2_b0", 32'(rx_q[base]),     32'h01);
        chk("t2_b1", 32'(rx_q[base + 1]), 32'h02);
        chk("t2_b2", 32'(rx_q[base + 2]), 32'h03);
        chk("t2_gap_cnt", 32'(gaps.size() - gbase), 32'd2);
        chk("t2_gap0", 32'(gaps[gbase]),     32'd2);
        chk("t2_gap1", 32'(gaps[gbase + 1]), 32'd2);
        chk("t2_empty", 32'(bus.empty), 32'd1);

        // 3: overflow with transmitter held busy
        hold = 1'b1;
        for (int i = 0; i < 16; i++) wr_byte(8'(8'h10 + i));
        chk("t3_full16",   32'(bus.full),     32'd1);
        chk("t3_count16",  32'(bus.count),    32'd16);
        chk("t3_no_ovf",   32'(bus.overflow), 32'd0);
        wr_byte(8'h20);
        chk("t3_ovf_set",  32'(bus.overflow), 32'd1);
        chk("t3_count_keep", 32'(bus.count),  32'd16);
        clr_ovf();
        chk("t3_ovf_clr",  32'(bus.overflow), 32'd0);
        bus.ovf_clr = 1'b1;
        wr_byte(8'h55);
        bus.ovf_clr = 1'b0;
        chk("t3_set_wins", 32'(bus.overflow), 32'd1);
        clr_ovf();
        base = rx_q.size();
        hold = 1'b0;
        wr_byte(8'h77);
        chk("t3_pop_no_rescue_ovf", 32'(bus.overflow), 32'd1);
        chk("t3_pop_count15",       32'(bus.count),    32'd15);
        chk("t3_launch",            32'(bus.start),    32'd1);
        clr_ovf();
        wait_rx("t3_rx_wait", base + 16, 4000);
        wait_idle("t3_idle", 1000);
        chk("t3_rx_size", 32'(rx_q.size() - base), 32'd16);
        errs = 0;
        for (int i = 0; i < 16; i++) if (rx_q[base + i] !== 8'(8'h10 + i)) errs++;
        chk("t3_rx_order", 32'(errs), 32'd0);

        // 4: wrap-around streaming of 40 incrementing bytes
        base = rx_q.size();
        hold = 1'b1;
        for (int i = 0; i < 10; i++) wr_byte(8'(i));
        hold = 1'b0;
        for (int i = 10; i < 40; i++) begin
            for (int k = 0; k < 400 && bus.count >= 10; k++) @(negedge bclk);
            wr_byte(8'(i));
        end
        wait_rx("t4_rx_wait", base + 40, 10000);
        wait_idle("t4_idle", 1000);
        chk("t4_rx_size", 32'(rx_q.size() - base), 32'd40);
        errs = 0;
        for (int i = 0; i < 40; i++) if (rx_q[base + i] !== 8'(i)) errs++;
        chk("t4_rx_order", 32'(errs), 32'd0);

        // 5: reset in the middle of the second of four frames
        base = rx_q.size();
        for (int i = 0; i < 4; i++) wr_byte(8'(8'hA0 + i));
        wait_rx("t5_rx_wait", base + 2, 600);
        repeat (5) @(negedge bclk);
        rst = 1'b0;
        #1;
        chk("t5_start",    32'(bus.start),    32'd0);
        chk("t5_tx_din",   32'(bus.tx_din),   32'h00);
        chk("t5_count",    32'(bus.count),    32'd0);
        chk("t5_empty",    32'(bus.empty),    32'd1);
        chk("t5_full",     32'(bus.full),     32'd0);
        chk("t5_overflow", 32'(bus.overflow), 32'd0);
        chk("t5_busy",     32'(bus.busy),     32'd0);
        repeat (2) @(negedge bclk);
        rst = 1'b1;
        repeat (60) @(negedge bclk);
        chk("t5_no_more_start", 32'(rx_q.size() - base), 32'd2);
        chk("t5_count_after",   32'(bus.count),          32'd0);

`ifdef UART_TX_FEEDER_TIMEOUT_EN
        // 6: transmitter never acknowledges, watchdog returns to IDLE
        mute = 1'b1;
        wr_byte(8'hC3);
        repeat (200) @(negedge bclk);
        chk("t6_err_early", 32'(bus.tx_err), 32'd0);
        for (int i = 0; i < 200 && !bus.tx_err; i++) @(negedge bclk);
        chk("t6_err_set", 32'(bus.tx_err), 32'd1);
        @(negedge bclk);
        chk("t6_idle", 32'(bus.busy), 32'd0);
        mute = 1'b0;
        clr_ovf();
        chk("t6_err_clr", 32'(bus.tx_err), 32'd0);
        base = rx_q.size();
        wr_byte(8'hC4);
        wait_rx("t6_rx_wait", base + 1, 50);
        chk("t6_next_byte", 32'(rx_q[base]), 32'hC4);
        wait_idle("t6_final_idle", 1000);
`endif

        chk("start_width", 32'(dbl_start), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_uart_tx_feeder

// File: doc/uart_tx_feeder.md
Name: uart_tx_feeder

Overview:
- Upstream stage of the UART transmitter; buffers bytes from the DDS control/readback logic in a small FIFO.
- Drains them one at a time into the transmitter through its start/tx_din/tx_done handshake.
- Runs on the transmitter's 16x-oversampled bit clock bclk, so no clock-domain crossing exists.
- Lets producers burst several bytes without tracking the ~160-cycle frame time.

Parameters:
- DEPTH_LOG2, 4: FIFO depth = 2**DEPTH_LOG2 bytes (16).
- TIMEOUT_CYC, 255: watchdog limit in bclk cycles. Used only when UART_TX_FEEDER_TIMEOUT_EN is defined.

Ports:
- bclk  input  1  16x baud clock, shared with the transmitter.
- rst  input  1  asynchronous, active-low reset.
- wr_en  input  1  producer write strobe, one byte per asserted cycle.
- wr_data  input  8  byte to enqueue.
- ovf_clr  input  1  clears the sticky overflow flag.
- tx_done  input  1  transmitter idle/done flag; high = idle.
- start  output  1  one-cycle launch pulse to the transmitter.
- tx_din  output  8  byte presented to the transmitter; valid while start=1.
- full  output  1  FIFO holds 2**DEPTH_LOG2 bytes.
- empty  output  1  FIFO holds 0 bytes.
- count  output  DEPTH_LOG2+1  current occupancy.
- overflow  output  1  sticky: a write was dropped.
- busy  output  1  FSM not in IDLE, or FIFO not empty.

Behaviour:
- Reset (async, rst=0) values: start=0, tx_din=8'h00, count=0, empty=1, full=0, overflow=0, busy=0, pointers=0, FSM=IDLE. FIFO RAM contents are not reset.
- Reset mid-frame: the FIFO is flushed. The transmitter shares rst, so both restart idle.
- Write rule:
  - wr_en=1 with full=0 at an edge: byte stored at wr_ptr, wr_ptr increments modulo depth.
  - wr_en=1 with full=1: byte dropped, overflow set.
  - A pop in the same cycle does not rescue a write while full=1.
- Pointers are DEPTH_LOG2 bits and wrap naturally. count is updated +1 on write, -1 on pop, unchanged when both occur.
- full and empty are derived from registered count.
- overflow: set by a dropped write, cleared by ovf_clr. If both occur in the same cycle, set wins.
- FSM states:
  - IDLE: if empty=0 and tx_done=1, then start<=1, tx_din<=mem[rd_ptr], pop (rd_ptr+1, count-1), go to LAUNCH.
  - LAUNCH: start<=0, go to WAIT_ACK. This gives exactly one cycle of start=1; the transmitter samples it at this edge.
  - WAIT_ACK: wait for tx_done=0, then go to WAIT_DONE.
  - WAIT_DONE: wait for tx_done=1, then go to IDLE.
- tx_din holds its value until the next launch.
- Latency: byte written at edge N into an idle, empty FIFO gives start=1 during the cycle after edge N+1, so the transmitter samples it at edge N+2.
- Back-to-back bytes: the next start follows tx_done's rise by 2 edges (WAIT_DONE→IDLE→launch).
- Write while IDLE and empty: the same-edge write is not visible until the next edge (empty is registered).
- tx_done low while in IDLE (transmitter owned elsewhere or still busy): no launch occurs.

Optional Feature:
- Macro: UART_TX_FEEDER_TIMEOUT_EN.
- When defined:
  - A cycle counter runs in WAIT_ACK and WAIT_DONE.
  - If it reaches TIMEOUT_CYC, the FSM returns to IDLE and sets an extra sticky output tx_err.
  - tx_err resets to 0 and is cleared by ovf_clr.
  - The popped byte is lost, not re-queued.
- When undefined: no counter, no tx_err port, and the FSM can wait forever.

Decomposition:
- Shared package uart_pkg: FSM state encoding (IDLE, LAUNCH, WAIT_ACK, WAIT_DONE), BYTE_W=8, FRAME_CYC=160 (bclk cycles per 10-bit frame), default DEPTH_LOG2.
- One natural sub-module: uart_sync_fifo (single-clock FIFO with count/full/empty). The feeder FSM sits in the top level.

Test Plan:
1. Single byte: reset, write 8'hA5 at edge N → start=1 for exactly one cycle starting after edge N+1, with tx_din=8'hA5. With the transmitter attached, the serial line shows 0,1,0,1,0,0,1,0,1,1 LSB-first, 16 cycles per bit.
2. Burst of 3 bytes (8'h01, 8'h02, 8'h03) on consecutive cycles → count reaches 3. Three start pulses, each 2 edges after tx_done rises; output order is 01,02,03; empty=1 and busy=0 at the end.
3. Overflow: write 17 bytes with the transmitter held busy (tx_done forced 0) → count=16, full=1, overflow=1, 17th byte absent from the output. ovf_clr → overflow=0.
4. Wrap-around: stream 40 incrementing bytes with occupancy kept between 2 and 15 → all 40 received in order; pointers wrap twice.
5. Reset mid-frame: deassert rst during byte 2 of 4 → all outputs reach their reset values immediately, no further start pulse, count=0.
6. (TIMEOUT_EN) Hold tx_done=1 after a launch → after 255 cycles FSM returns to IDLE, tx_err=1, next byte launches normally.
